// File: rtl/noc_pkg.sv
// Shared definitions for the mesh-NoC router input stage: direction codes,
// routing-algorithm selectors and flit field placement helpers.
package noc_pkg;

    localparam int DIR_WIDTH = 3;

    localparam logic [DIR_WIDTH-1:0] DIR_N       = 3'b000;
    localparam logic [DIR_WIDTH-1:0] DIR_S       = 3'b001;
    localparam logic [DIR_WIDTH-1:0] DIR_E       = 3'b010;
    localparam logic [DIR_WIDTH-1:0] DIR_W       = 3'b011;
    localparam logic [DIR_WIDTH-1:0] DIR_L       = 3'b100;
    localparam logic [DIR_WIDTH-1:0] DIR_INVALID = 3'b111;

    localparam int ALG_XY = 0;
    localparam int ALG_YX = 1;

    // Destination X sits in the top RRSIZE bits of the flit.
    function automatic int dest_x_lsb(input int dsize, input int rrsize);
        return dsize - rrsize;
    endfunction

    // Destination Y sits directly below destination X.
    function automatic int dest_y_lsb(input int dsize, input int rrsize);
        return dsize - 2 * rrsize;
    endfunction

endpackage

// File: rtl/noc_route_compute.sv
// Combinational dimension-order route computation: compares the flit's
// destination coordinates against this router's coordinates (unsigned) and
// yields the output direction code. ALGORITHM selects XY or YX ordering.
module noc_route_compute
    import noc_pkg::*;
#(
    parameter int                RRSIZE    = 8,
    parameter logic [RRSIZE-1:0] ROUTER_X  = 1,
    parameter logic [RRSIZE-1:0] ROUTER_Y  = 1,
    parameter int                ALGORITHM = ALG_XY
) (
    input  logic [RRSIZE-1:0]    dest_x,
    input  logic [RRSIZE-1:0]    dest_y,
    output logic [DIR_WIDTH-1:0] dir
);

    // Resolve one dimension fully before looking at the other one.
    always_comb begin
        dir = DIR_INVALID;
        if (ALGORITHM == ALG_YX) begin
            if (dest_y > ROUTER_Y) begin
                dir = DIR_S;
            end else if (dest_y < ROUTER_Y) begin
                dir = DIR_N;
            end else if (dest_x > ROUTER_X) begin
                dir = DIR_E;
            end else if (dest_x < ROUTER_X) begin
                dir = DIR_W;
            end else begin
                dir = DIR_L;
            end
        end else begin
            if (dest_x > ROUTER_X) begin
                dir = DIR_E;
            end else if (dest_x < ROUTER_X) begin
                dir = DIR_W;
            end else if (dest_y > ROUTER_Y) begin
                dir = DIR_S;
            end else if (dest_y < ROUTER_Y) begin
                dir = DIR_N;
            end else begin
                dir = DIR_L;
            end
        end
    end

endmodule

// File: rtl/noc_input_module.sv
// Input stage of one mesh-NoC router port. Pops the upstream FIFO whenever it
// holds a flit, registers the flit and its routed direction code, and emits an
// INVALID bubble on cycles without a flit.
// Optional feature: define UTURN_CHECK_EN to turn a route back out of the
// arrival port (other than Local) into INVALID.
module noc_input_module
    import noc_pkg::*;
#(
    parameter int                MSB_SLOT  = 5,
    parameter int                DSIZE     = 1 << MSB_SLOT,
    parameter int                RRSIZE    = 1 << (MSB_SLOT - 2),
    parameter int                ADDRSIZE  = 5,
    parameter int                DEPTH     = 1 << ADDRSIZE,
    parameter logic [2:0]        PORT      = 3'b000,
    parameter logic [RRSIZE-1:0] ROUTER_X  = 1,
    parameter logic [RRSIZE-1:0] ROUTER_Y  = 1,
    parameter int                algorithm = ALG_XY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DSIZE-1:0]     data_in,
    input  logic                 input_empty,
    output logic                 input_read,
    output logic [DSIZE-1:0]     data_out,
    output logic [DIR_WIDTH-1:0] vc_select
);

    localparam int X_LSB = dest_x_lsb(DSIZE, RRSIZE);
    localparam int Y_LSB = dest_y_lsb(DSIZE, RRSIZE);

    // The FIFO geometry is carried for integration only; still, reject
    // inconsistent parameter sets at elaboration rather than misroute.
    if (DSIZE != (1 << MSB_SLOT)) begin : g_bad_dsize
        $error("noc_input_module: DSIZE must equal 1<<MSB_SLOT");
    end
    if (DEPTH != (1 << ADDRSIZE)) begin : g_bad_depth
        $error("noc_input_module: DEPTH must equal 1<<ADDRSIZE");
    end
    if (2 * RRSIZE > DSIZE) begin : g_bad_rrsize
        $error("noc_input_module: coordinate fields exceed flit width");
    end
    if (algorithm != ALG_XY && algorithm != ALG_YX) begin : g_bad_alg
        $error("noc_input_module: algorithm must be 0 (XY) or 1 (YX)");
    end

    logic [RRSIZE-1:0]    dest_x;
    logic [RRSIZE-1:0]    dest_y;
    logic [DIR_WIDTH-1:0] raw_dir;
    logic [DIR_WIDTH-1:0] next_vc;

    assign dest_x = data_in[X_LSB +: RRSIZE];
    assign dest_y = data_in[Y_LSB +: RRSIZE];

    // Popping is gated by reset so nothing is consumed while the stage is held.
    assign input_read = reset & ~input_empty;

    noc_route_compute #(
        .RRSIZE    (RRSIZE),
        .ROUTER_X  (ROUTER_X),
        .ROUTER_Y  (ROUTER_Y),
        .ALGORITHM (algorithm)
    ) u_route (
        .dest_x (dest_x),
        .dest_y (dest_y),
        .dir    (raw_dir)
    );

    // Optionally suppress routes that would send the flit back where it came from.
    always_comb begin
        next_vc = raw_dir;
`ifdef UTURN_CHECK_EN
        if ((raw_dir == PORT) && (raw_dir != DIR_L)) begin
            next_vc = DIR_INVALID;
        end
`else
        if (PORT == DIR_INVALID) begin
            next_vc = raw_dir;
        end
`endif
    end

    // Capture a flit when one is popped; otherwise keep the data and mark a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            vc_select <= DIR_INVALID;
        end else if (input_read) begin
            data_out  <= data_in;
            vc_select <= next_vc;
        end else begin
            vc_select <= DIR_INVALID;
        end
    end

endmodule

// File: tb/tb_noc_input_module.sv
// Scoreboard bench for noc_input_module. Two instances share the stimulus:
// one with XY routing and one with YX routing, both at router (1,1), PORT=N.
module tb_noc_input_module;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  vc_xy;
        logic [2:0]  vc_yx;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic        input_empty;
    logic        read_xy;
    logic        read_yx;
    logic [31:0] data_out_xy;
    logic [31:0] data_out_yx;
    logic [2:0]  vc_xy;
    logic [2:0]  vc_yx;

    exp_t        sb[$];
    logic [31:0] last_data;
    int          checks;
    int          passes;

    noc_input_module #(
        .PORT      (3'b000),
        .ROUTER_X  (8'd1),
        .ROUTER_Y  (8'd1),
        .algorithm (0)
    ) dut_xy (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .input_empty (input_empty),
        .input_read  (read_xy),
        .data_out    (data_out_xy),
        .vc_select   (vc_xy)
    );

    noc_input_module #(
        .PORT      (3'b000),
        .ROUTER_X  (8'd1),
        .ROUTER_Y  (8'd1),
        .algorithm (1)
    ) dut_yx (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .input_empty (input_empty),
        .input_read  (read_yx),
        .data_out    (data_out_yx),
        .vc_select   (vc_yx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A North route arriving on the North port is a u-turn when the check is built in.
    function automatic logic [2:0] north_route();
`ifdef UTURN_CHECK_EN
        return 3'b111;
`else
        return 3'b000;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
        end else begin
            passes++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and record what the
    // registers must hold after the following rising edge.
    task automatic applyStimulus(input logic [31:0] data, input logic empty,
                                 input logic [2:0] exp_xy, input logic [2:0] exp_yx);
        exp_t e;
        @(negedge clk);
        data_in     = data;
        input_empty = empty;
        if (!empty) last_data = data;
        e.data  = last_data;
        e.vc_xy = empty ? 3'b111 : exp_xy;
        e.vc_yx = empty ? 3'b111 : exp_yx;
        sb.push_back(e);
        #1;
        checkOutput("input_read_xy", {31'd0, read_xy}, {31'd0, ~empty});
        checkOutput("input_read_yx", {31'd0, read_yx}, {31'd0, ~empty});
    endtask

    task automatic drainScoreboard();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    // Monitor: after every rising edge, compare registered outputs to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("data_out_xy", data_out_xy, e.data);
                checkOutput("data_out_yx", data_out_yx, e.data);
                checkOutput("vc_select_xy", {29'd0, vc_xy}, {29'd0, e.vc_xy});
                checkOutput("vc_select_yx", {29'd0, vc_yx}, {29'd0, e.vc_yx});
            end
        end
    end

    initial begin
        exp_t e;
        checks      = 0;
        passes      = 0;
        last_data   = 32'h0;
        reset       = 1'b0;
        input_empty = 1'b0;
        data_in     = 32'h01010001;

        // Held in reset with a flit available: nothing popped, outputs cleared.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_read", {31'd0, read_xy}, 32'd0);
        checkOutput("rst_data", data_out_xy, 32'd0);
        checkOutput("rst_vc", {29'd0, vc_xy}, 32'd7);
        checkOutput("rst_vc_yx", {29'd0, vc_yx}, 32'd7);

        // Release and present a flit addressed to this router.
        @(negedge clk);
        reset     = 1'b1;
        data_in   = 32'h01010001;
        last_data = 32'h01010001;
        e.data = 32'h01010001; e.vc_xy = 3'b100; e.vc_yx = 3'b100;
        sb.push_back(e);
        #1;
        checkOutput("rel_read", {31'd0, read_xy}, 32'd1);

        applyStimulus(32'h01020001, 1'b0, 3'b001, 3'b001);
        applyStimulus(32'h00010001, 1'b0, 3'b011, 3'b011);
        applyStimulus(32'h02010001, 1'b0, 3'b010, 3'b010);
        applyStimulus(32'h01000001, 1'b0, north_route(), north_route());
        applyStimulus(32'h02020001, 1'b0, 3'b010, 3'b001);
        applyStimulus(32'hDEADBEEF, 1'b1, 3'b111, 3'b111);
        applyStimulus(32'h12345678, 1'b1, 3'b111, 3'b111);
        applyStimulus(32'h00000001, 1'b0, 3'b011, north_route());
        applyStimulus(32'hFF01ABCD, 1'b0, 3'b010, 3'b010);
        applyStimulus(32'h01FF0000, 1'b0, 3'b001, 3'b001);
        drainScoreboard();

        // Mid-stream reset: a flit is waiting, reset drops between edges.
        @(negedge clk);
        data_in     = 32'h02020002;
        input_empty = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_data", data_out_xy, 32'd0);
        checkOutput("mid_rst_vc", {29'd0, vc_xy}, 32'd7);
        checkOutput("mid_rst_read", {31'd0, read_xy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held_rst_data", data_out_yx, 32'd0);
        checkOutput("held_rst_vc", {29'd0, vc_yx}, 32'd7);

        // Resume on the first edge after release.
        @(negedge clk);
        reset     = 1'b1;
        data_in   = 32'h01010001;
        last_data = 32'h01010001;
        e.data = 32'h01010001; e.vc_xy = 3'b100; e.vc_yx = 3'b100;
        sb.push_back(e);
        applyStimulus(32'h00020003, 1'b0, 3'b011, 3'b001);
        drainScoreboard();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
